bird_physics: RTL and testbench

BIRD_PHYSICS -- requirements
Module: bird_physics

---
 rtl/bird_physics.sv | 128 ++++++++++++
 tb/tb_bird_physics.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_physics.sv
// Vertical flight physics for the bird sprite: flap edge capture,
// gravity, ceiling clamp and floor death, advanced once per game tick.
module bird_physics #(
    parameter int POS_W   = 10,
    parameter int VEL_W   = 6,
    parameter int MIN_Y   = 45,
    parameter int MAX_Y   = 426,
    parameter int HEIGHT  = 19,
    parameter int START_Y = 235,
    parameter int GRAVITY = 1,
    parameter int FLAP_V  = 6,
    parameter int VMAX    = 8
) (
    input  logic             game_clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btnup,
    input  logic             restart,
    output logic [POS_W-1:0] bird_pic_t,
    output logic [POS_W-1:0] bird_pic_b,
    output logic [VEL_W-1:0] vel,
    output logic [1:0]       state,
    output logic             hit_floor
);

    localparam int AW = POS_W + 2;

    localparam logic signed [AW-1:0] GRAV_S = AW'(GRAVITY);
    localparam logic signed [AW-1:0] FLAP_S = AW'(-FLAP_V);
    localparam logic signed [AW-1:0] VMAX_S = AW'(VMAX);
    localparam logic signed [AW-1:0] MIN_S  = AW'(MIN_Y);
    localparam logic signed [AW-1:0] MAX_S  = AW'(MAX_Y);
    localparam logic signed [AW-1:0] HGT_S  = AW'(HEIGHT);

    localparam logic [POS_W-1:0] START_P = POS_W'(START_Y);
    localparam logic [POS_W-1:0] MIN_P   = POS_W'(MIN_Y);
    localparam logic [POS_W-1:0] FLOOR_P = POS_W'(MAX_Y - HEIGHT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  y_q, y_d;
    logic [VEL_W-1:0]  vel_q, vel_d;
    logic              pend_q;
    logic              btn_q;
    logic              hit_q, hit_d;

    logic              btn_edge;
    logic              flap;
    logic signed [AW-1:0] vel_ext, vel_inc, vel_new, y_new;

    assign btn_edge = btnup & ~btn_q;
    assign flap     = pend_q | btn_edge;

    // Position uses the freshly computed velocity, evaluated wide enough
    // that neither the ceiling nor the floor comparison can wrap.
    always_comb begin
        vel_ext = {{(AW-VEL_W){vel_q[VEL_W-1]}}, vel_q};
        vel_inc = vel_ext + GRAV_S;
        if (flap)
            vel_new = FLAP_S;
        else if (vel_inc > VMAX_S)
            vel_new = VMAX_S;
        else
            vel_new = vel_inc;
        y_new   = $signed({2'b00, y_q}) + vel_new;
        state_d = FLY;
        hit_d   = 1'b0;
        y_d     = y_new[POS_W-1:0];
        vel_d   = vel_new[VEL_W-1:0];
        if (y_new < MIN_S) begin
            y_d   = MIN_P;
            vel_d = '0;
        end else if (y_new + HGT_S > MAX_S) begin
            y_d     = FLOOR_P;
            vel_d   = '0;
            state_d = DEAD;
            hit_d   = 1'b1;
        end
    end

    always_ff @(posedge game_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            y_q     <= START_P;
            vel_q   <= '0;
            pend_q  <= 1'b0;
            btn_q   <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            btn_q <= btnup;
            hit_q <= 1'b0;
            unique case (state_q)
                IDLE, FLY: begin
                    if (tick && (state_q == FLY || flap)) begin
                        state_q <= state_d;
                        y_q     <= y_d;
                        vel_q   <= vel_d;
                        hit_q   <= hit_d;
                        pend_q  <= 1'b0;
                    end else if (btn_edge) begin
                        pend_q <= 1'b1;
                    end
                end
                DEAD: begin
                    if (restart) begin
                        state_q <= IDLE;
                        y_q     <= START_P;
                        vel_q   <= '0;
                        pend_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bird_pic_t = y_q;
    assign bird_pic_b = y_q + POS_W'(HEIGHT - 1);
    assign vel        = vel_q;
    assign state      = state_q;
    assign hit_floor  = hit_q;

endmodule

// File: tb/tb_bird_physics.sv
// Scenario tasks plus a randomized run, all compared against an
// integer model of the flight rules.
module tb_bird_physics;

    localparam int MIN_Y   = 45;
    localparam int MAX_Y   = 426;
    localparam int HEIGHT  = 19;
    localparam int START_Y = 235;
    localparam int GRAVITY = 1;
    localparam int FLAP_V  = 6;
    localparam int VMAX    = 8;

    logic       game_clk = 1'b0;
    logic       rst, tick, btnup, restart;
    logic [9:0] bird_pic_t, bird_pic_b;
    logic [5:0] vel;
    logic [1:0] state;
    logic       hit_floor;

    int checks = 0;
    int passes = 0;

    int m_state, m_y, m_vel;
    bit m_pend, m_prev, m_hit;

    bird_physics dut (
        .game_clk  (game_clk),
        .rst       (rst),
        .tick      (tick),
        .btnup     (btnup),
        .restart   (restart),
        .bird_pic_t(bird_pic_t),
        .bird_pic_b(bird_pic_b),
        .vel       (vel),
        .state     (state),
        .hit_floor (hit_floor)
    );

    always #5 game_clk = ~game_clk;

    function automatic int dvel();
        return int'($signed(vel));
    endfunction

    task automatic model_reset();
        m_state = 0;
        m_y     = START_Y;
        m_vel   = 0;
        m_pend  = 0;
        m_prev  = 0;
        m_hit   = 0;
    endtask

    // One game_clk cycle of the flight rules, in plain integers.
    task automatic model_clk(input bit t, input bit b, input bit r);
        bit e, f;
        int vn, yn;
        e      = b && !m_prev;
        m_prev = b;
        m_hit  = 0;
        f      = m_pend || e;
        if (m_state == 2) begin
            if (r) begin
                m_state = 0;
                m_y     = START_Y;
                m_vel   = 0;
                m_pend  = 0;
            end
        end else if (t && (m_state == 1 || f)) begin
            if (f) vn = -FLAP_V;
            else   vn = (m_vel + GRAVITY > VMAX) ? VMAX : m_vel + GRAVITY;
            yn     = m_y + vn;
            m_pend = 0;
            if (yn < MIN_Y) begin
                m_y = MIN_Y; m_vel = 0; m_state = 1;
            end else if (yn + HEIGHT > MAX_Y) begin
                m_y = MAX_Y - HEIGHT; m_vel = 0;
                m_state = 2; m_hit = 1;
            end else begin
                m_y = yn; m_vel = vn; m_state = 1;
            end
        end else if (e) begin
            m_pend = 1;
        end
    endtask

    task automatic step(input bit t, input bit b, input bit r);
        tick    = t;
        btnup   = b;
        restart = r;
        @(posedge game_clk);
        model_clk(t, b, r);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (state !== 2'd0 || bird_pic_t !== 10'd235 ||
            bird_pic_b !== 10'd253 || vel !== 6'd0 ||
            hit_floor !== 1'b0)
            $display("FAIL reset: t=%0d b=%0d v=%0d s=%0d h=%b want 235 253 0 0 0",
                     bird_pic_t, bird_pic_b, dvel(), state, hit_floor);
        else passes++;
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            checks++;
            if (state !== 2'd0 || bird_pic_t !== 10'd235 ||
                bird_pic_b !== 10'd253 || vel !== 6'd0)
                $display("FAIL idle_hold[%0d]: t=%0d b=%0d v=%0d s=%0d want 235 253 0 0",
                         i, bird_pic_t, bird_pic_b, dvel(), state);
            else passes++;
        end
    endtask

    task automatic test_first_flap();
        int ev[3];
        int et[3];
        ev = '{-6, -5, -4};
        et = '{229, 224, 220};
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0);
            checks++;
            if (state !== 2'd1 || dvel() != ev[i] ||
                int'(bird_pic_t) != et[i])
                $display("FAIL first_flap[%0d]: s=%0d v=%0d t=%0d want 1 %0d %0d",
                         i, state, dvel(), bird_pic_t, ev[i], et[i]);
            else passes++;
            step(0, 1, 0);
        end
    endtask

    task automatic test_edge_with_tick();
        step(0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, 0, 0);
        checks++;
        if (dvel() != 3 || bird_pic_t !== 10'd220)
            $display("FAIL pre_edge: v=%0d t=%0d want 3 220",
                     dvel(), bird_pic_t);
        else passes++;
        step(1, 1, 0);
        checks++;
        if (dvel() != -6 || bird_pic_t !== 10'd214)
            $display("FAIL edge_tick: v=%0d t=%0d want -6 214",
                     dvel(), bird_pic_t);
        else passes++;
        step(0, 1, 0);
        step(1, 1, 0);
        checks++;
        if (dvel() != -5 || bird_pic_t !== 10'd209)
            $display("FAIL pend_clear: v=%0d t=%0d want -5 209",
                     dvel(), bird_pic_t);
        else passes++;
    endtask

    task automatic test_ceiling();
        int guard = 0;
        while (m_y - FLAP_V >= MIN_Y && guard < 100) begin
            step(0, 0, 0);
            step(1, 1, 0);
            guard++;
        end
        checks++;
        if (int'(bird_pic_t) != m_y || dvel() != m_vel)
            $display("FAIL ceil_approach: t=%0d v=%0d want %0d %0d",
                     bird_pic_t, dvel(), m_y, m_vel);
        else passes++;
        step(0, 0, 0);
        step(1, 1, 0);
        checks++;
        if (bird_pic_t !== 10'd45 || vel !== 6'd0 || state !== 2'd1)
            $display("FAIL ceil_clamp: t=%0d v=%0d s=%0d want 45 0 1",
                     bird_pic_t, dvel(), state);
        else passes++;
        step(1, 0, 0);
        checks++;
        if (bird_pic_t !== 10'd46 || dvel() != 1)
            $display("FAIL ceil_next: t=%0d v=%0d want 46 1",
                     bird_pic_t, dvel());
        else passes++;
    endtask

    task automatic test_floor();
        int guard = 0;
        while (m_state != 2 && guard < 200) begin
            step(1, 0, 0);
            checks++;
            if (hit_floor !== m_hit || int'(bird_pic_t) != m_y)
                $display("FAIL fall[%0d]: t=%0d h=%b want %0d %b",
                         guard, bird_pic_t, hit_floor, m_y, m_hit);
            else passes++;
            guard++;
        end
        checks++;
        if (state !== 2'd2 || bird_pic_t !== 10'd407 ||
            bird_pic_b !== 10'd425 || vel !== 6'd0 ||
            hit_floor !== 1'b1)
            $display("FAIL floor_hit: s=%0d t=%0d b=%0d v=%0d h=%b want 2 407 425 0 1",
                     state, bird_pic_t, bird_pic_b, dvel(), hit_floor);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            step(1, i[0], 0);
            checks++;
            if (state !== 2'd2 || bird_pic_t !== 10'd407 ||
                vel !== 6'd0 || hit_floor !== 1'b0)
                $display("FAIL dead_hold[%0d]: s=%0d t=%0d v=%0d h=%b want 2 407 0 0",
                         i, state, bird_pic_t, dvel(), hit_floor);
            else passes++;
        end
    endtask

    task automatic test_restart();
        step(0, 0, 1);
        checks++;
        if (state !== 2'd0 || bird_pic_t !== 10'd235 || vel !== 6'd0)
            $display("FAIL restart: s=%0d t=%0d v=%0d want 0 235 0",
                     state, bird_pic_t, dvel());
        else passes++;
        step(1, 0, 1);
        checks++;
        if (state !== 2'd0 || bird_pic_t !== 10'd235)
            $display("FAIL restart_idle: s=%0d t=%0d want 0 235",
                     state, bird_pic_t);
        else passes++;
    endtask

    task automatic test_reset_midflight();
        step(0, 1, 0);
        step(1, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        checks++;
        if (state !== 2'd1)
            $display("FAIL pre_reset_fly: s=%0d want 1", state);
        else passes++;
        #3 rst = 1'b1;
        #1;
        checks++;
        if (state !== 2'd0 || bird_pic_t !== 10'd235 ||
            vel !== 6'd0 || hit_floor !== 1'b0)
            $display("FAIL reset_fly: s=%0d t=%0d v=%0d h=%b want 0 235 0 0",
                     state, bird_pic_t, dvel(), hit_floor);
        else passes++;
        tick = 1'b1;
        @(posedge game_clk);
        #1;
        checks++;
        if (hit_floor !== 1'b0 || state !== 2'd0)
            $display("FAIL reset_hold: h=%b s=%0d want 0 0",
                     hit_floor, state);
        else passes++;
        btnup = 1'b0;
        tick  = 1'b0;
        model_reset();
        #2 rst = 1'b0;
    endtask

    task automatic test_random();
        bit t, b, r;
        for (int i = 0; i < 1500; i++) begin
            t = ($urandom_range(0, 2) == 0);
            b = ($urandom_range(0, 4) == 0) ? ~btnup : btnup;
            r = ($urandom_range(0, 9) == 0);
            step(t, b, r);
            checks++;
            if (int'(state) != m_state || int'(bird_pic_t) != m_y ||
                int'(bird_pic_b) != m_y + HEIGHT - 1 ||
                dvel() != m_vel || hit_floor !== m_hit)
                $display("FAIL random[%0d]: s=%0d t=%0d b=%0d v=%0d h=%b want %0d %0d %0d %0d %b",
                         i, state, bird_pic_t, bird_pic_b, dvel(),
                         hit_floor, m_state, m_y, m_y + HEIGHT - 1,
                         m_vel, m_hit);
            else passes++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        tick    = 1'b0;
        btnup   = 1'b0;
        restart = 1'b0;
        model_reset();
        #12;
        test_reset();
        rst = 1'b0;
        #1;
        test_idle_hold();
        test_first_flap();
        test_edge_with_tick();
        test_ceiling();
        test_floor();
        test_restart();
        test_reset_midflight();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
